// File: rtl/dkong_input_pkg.sv
// Shared constants and types for the dkong input conditioner.
// Bit indices of the packed input vector and coin FSM encoding.
package dkong_input_pkg;

  localparam int NUM_INPUTS = 13;

  localparam int IDX_P1_R  = 0;
  localparam int IDX_P1_L  = 1;
  localparam int IDX_P1_U  = 2;
  localparam int IDX_P1_D  = 3;
  localparam int IDX_P1_B1 = 4;
  localparam int IDX_P2_R  = 5;
  localparam int IDX_P2_L  = 6;
  localparam int IDX_P2_U  = 7;
  localparam int IDX_P2_D  = 8;
  localparam int IDX_P2_B1 = 9;
  localparam int IDX_P1_SW = 10;
  localparam int IDX_P2_SW = 11;
  localparam int IDX_COIN  = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_REL = 2'd2
  } coin_state_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dkong_debounce.sv
// Single-bit 2-flop synchroniser followed by a counting debouncer.
// The stable value only moves after DEBOUNCE_CYCLES consecutive mismatches.
module dkong_debounce
  import dkong_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Synchronise, then count consecutive disagreements with the stable value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/dkong_input_conditioner.sv
// Player/cabinet input front-end: sync, debounce, registered levels, coin pulse.
// Optional macro DKONG_SOCD_CLEAN_EN cancels opposing joystick directions.
module dkong_input_conditioner
  import dkong_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int COIN_PULSE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW_IN     = 1'b0
) (
  input  logic       masterclk,
  input  logic       rst_n,
  input  logic [4:0] raw_p1,
  input  logic [4:0] raw_p2,
  input  logic       raw_p1_sw,
  input  logic       raw_p2_sw,
  input  logic       raw_coin,
  output logic       p1_r,
  output logic       p1_l,
  output logic       p1_u,
  output logic       p1_d,
  output logic       p1_b1,
  output logic       p2_r,
  output logic       p2_l,
  output logic       p2_u,
  output logic       p2_d,
  output logic       p2_b1,
  output logic       p1_sw,
  output logic       p2_sw,
  output logic       coin_sw,
  output logic       input_event
);

  localparam int CCW = cnt_w(COIN_PULSE_CYCLES);
  localparam logic [CCW-1:0] C_LAST = CCW'(COIN_PULSE_CYCLES - 1);

  logic [NUM_INPUTS-1:0] w_raw;
  logic [NUM_INPUTS-1:0] w_stable;
  logic [11:0]           w_clean;
  logic                  w_coin_rise;

  logic [NUM_INPUTS-1:0] r_prev;
  logic [11:0]           r_out;
  logic                  r_event;

  coin_state_t           r_state;
  coin_state_t           w_state_nx;
  logic [CCW-1:0]        r_ccnt;
  logic [CCW-1:0]        w_ccnt_nx;
  logic                  r_coin;
  logic                  w_coin_nx;

  assign w_raw = {raw_coin, raw_p2_sw, raw_p1_sw, raw_p2, raw_p1}
               ^ {NUM_INPUTS{ACTIVE_LOW_IN}};

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_db
    dkong_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (masterclk),
      .rst_n   (rst_n),
      .i_raw   (w_raw[g]),
      .o_stable(w_stable[g])
    );
  end

  // Opposing-direction cleanup ahead of the output register.
  always_comb begin
    w_clean = w_stable[11:0];
`ifdef DKONG_SOCD_CLEAN_EN
    if (w_stable[IDX_P1_L] && w_stable[IDX_P1_R]) begin
      w_clean[IDX_P1_L] = 1'b0;
      w_clean[IDX_P1_R] = 1'b0;
    end
    if (w_stable[IDX_P1_U] && w_stable[IDX_P1_D]) begin
      w_clean[IDX_P1_U] = 1'b0;
      w_clean[IDX_P1_D] = 1'b0;
    end
    if (w_stable[IDX_P2_L] && w_stable[IDX_P2_R]) begin
      w_clean[IDX_P2_L] = 1'b0;
      w_clean[IDX_P2_R] = 1'b0;
    end
    if (w_stable[IDX_P2_U] && w_stable[IDX_P2_D]) begin
      w_clean[IDX_P2_U] = 1'b0;
      w_clean[IDX_P2_D] = 1'b0;
    end
`endif
  end

  assign w_coin_rise = w_stable[IDX_COIN] & ~r_prev[IDX_COIN];

  // Register clean levels and strobe on any change of the raw stable set.
  always_ff @(posedge masterclk) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_prev  <= '0;
      r_event <= 1'b0;
    end else begin
      r_out   <= w_clean;
      r_prev  <= w_stable;
      r_event <= |(w_stable ^ r_prev);
    end
  end

  // Coin FSM state, pulse counter and registered pulse output.
  always_ff @(posedge masterclk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ccnt  <= '0;
      r_coin  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ccnt  <= w_ccnt_nx;
      r_coin  <= w_coin_nx;
    end
  end

  // Coin FSM: one fixed-width pulse per debounced press.
  always_comb begin
    w_state_nx = r_state;
    w_ccnt_nx  = r_ccnt;
    w_coin_nx  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_coin_rise) begin
          w_state_nx = PULSE;
          w_ccnt_nx  = '0;
          w_coin_nx  = 1'b1;
        end
      end
      PULSE: begin
        if (r_ccnt == C_LAST) begin
          w_ccnt_nx  = '0;
          w_state_nx = w_stable[IDX_COIN] ? WAIT_REL : IDLE;
        end else begin
          w_ccnt_nx = r_ccnt + 1'b1;
          w_coin_nx = 1'b1;
        end
      end
      WAIT_REL: begin
        if (!w_stable[IDX_COIN]) begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_ccnt_nx  = '0;
      end
    endcase
  end

  assign p1_r        = r_out[IDX_P1_R];
  assign p1_l        = r_out[IDX_P1_L];
  assign p1_u        = r_out[IDX_P1_U];
  assign p1_d        = r_out[IDX_P1_D];
  assign p1_b1       = r_out[IDX_P1_B1];
  assign p2_r        = r_out[IDX_P2_R];
  assign p2_l        = r_out[IDX_P2_L];
  assign p2_u        = r_out[IDX_P2_U];
  assign p2_d        = r_out[IDX_P2_D];
  assign p2_b1       = r_out[IDX_P2_B1];
  assign p1_sw       = r_out[IDX_P1_SW];
  assign p2_sw       = r_out[IDX_P2_SW];
  assign coin_sw     = r_coin;
  assign input_event = r_event;

endmodule

// File: doc/dkong_input_conditioner.md
Name: dkong_input_conditioner

Overview:
- Front-end for all player and cabinet inputs; sits directly upstream of dkong_system.
- Synchronises the raw, asynchronous, bouncy pin inputs (joysticks, buttons, start switches, coin) into masterclk.
- Debounces each input and drives clean levels into the dkong_system joystick, button, start and coin ports.
- Converts a coin insertion into one fixed-width coin pulse, as the game's coin logic expects.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive masterclk cycles a synchronised input must differ from its stable value before the stable value changes; legal range is ≥2.
- COIN_PULSE_CYCLES, 1000000: width of the coin_sw pulse in masterclk cycles; legal range is ≥1.
- ACTIVE_LOW_IN, 0: when 1, all raw inputs are inverted at the pin, so a low pin means pressed.

Ports:
- masterclk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- raw_p1  in  5  raw P1 {b1,d,u,l,r}, asynchronous
- raw_p2  in  5  raw P2 {b1,d,u,l,r}, asynchronous
- raw_p1_sw  in  1  raw P1 start
- raw_p2_sw  in  1  raw P2 start
- raw_coin  in  1  raw coin switch
- p1_r, p1_l, p1_u, p1_d, p1_b1  out  1 each  clean P1 levels, active-high
- p2_r, p2_l, p2_u, p2_d, p2_b1  out  1 each  clean P2 levels, active-high
- p1_sw, p2_sw  out  1 each  clean start levels
- coin_sw  out  1  coin pulse
- input_event  out  1  one-cycle strobe, high on any debounced-state change

Behaviour:
- Clocking and reset:
  - Single clock, masterclk; every flop updates on its rising edge.
  - rst_n is synchronous and active-low.
  - Reset clears sync flops, stable values, counters, the coin FSM and all outputs to 0.
  - Reset mid-debounce or mid-coin-pulse aborts immediately; coin_sw is 0 on the first cycle after reset.
- Sync stage:
  - Per bit: optional inversion (ACTIVE_LOW_IN), then a 2-flop synchroniser.
- Debounce, per bit (13 instances):
  - Holds a stable value and a counter of width $clog2(DEBOUNCE_CYCLES).
  - If sync == stable: counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: stable <= sync and counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any mismatch gap restarts the count, so glitches shorter than DEBOUNCE_CYCLES never propagate.
  - The counter saturates by construction and never wraps.
- Output stage and latency:
  - Outputs are registered from the stable values.
  - Latency from the first sampled edge of a clean raw transition to the output = 2 + DEBOUNCE_CYCLES + 1 cycles.
  - input_event is high for exactly one cycle, aligned with the output change, when any stable bit changes; simultaneous changes produce a single strobe.
- Coin FSM:
  - States: IDLE, PULSE, WAIT_REL.
  - IDLE -> PULSE on a rising edge of the stable coin value; coin_sw goes high on the same cycle the p-outputs would change.
  - PULSE: coin_sw=1 for exactly COIN_PULSE_CYCLES cycles, then -> WAIT_REL if coin is still stable-high, else -> IDLE.
  - WAIT_REL -> IDLE when stable coin = 0.
  - A coin held or re-pressed during PULSE does not retrigger or extend the pulse.
  - One pulse per press, regardless of how long the coin is held.
- Start switches and buttons are pure levels; no edge processing.

Optional Feature:
- Macro: DKONG_SOCD_CLEAN_EN.
- Defined: applied per player in the output register stage.
  - If stable l and r are both 1, both p_l and p_r outputs are 0.
  - If stable u and d are both 1, both p_u and p_d outputs are 0.
  - Latency is unchanged.
  - input_event still reflects stable-value changes, not the cleaned outputs.
- Undefined: opposing directions pass through unchanged.

Decomposition:
- Package dkong_input_pkg:
  - NUM_INPUTS = 13.
  - Bit-index constants IDX_P1_R..IDX_P1_B1 (0-4), IDX_P2_R..IDX_P2_B1 (5-9), IDX_P1_SW = 10, IDX_P2_SW = 11, IDX_COIN = 12.
  - Coin FSM state encoding: IDLE = 2'd0, PULSE = 2'd1, WAIT_REL = 2'd2.
- Sub-module dkong_debounce:
  - Single bit: 2-flop sync plus counter and stable flop, parameterised by DEBOUNCE_CYCLES.
  - Instantiated NUM_INPUTS times in a generate loop.
- Top level holds the inversion, output regs, SOCD logic, event strobe and coin FSM.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, COIN_PULSE_CYCLES=8 unless stated.
- Reset: hold rst_n=0 for 3 cycles with all raw inputs =1 -> all outputs 0 throughout; after release, outputs rise exactly 7 cycles after raw was first sampled.
- Glitch rejection: raw_p1[0] pulses high for 3 cycles, then low -> p1_r stays 0 and input_event never fires. A 4-cycle-stable pulse -> p1_r=1 for ≥1 cycle and input_event fires once.
- Coin: raw_coin high for 20 cycles -> coin_sw high for exactly 8 cycles, one pulse only. Release for 10 cycles and press again -> second 8-cycle pulse.
- Coin bounce: raw_coin toggles every 2 cycles for 16 cycles, then stays high -> exactly one 8-cycle pulse, starting 7 cycles after the final rise.
- Reset mid-pulse: assert rst_n=0 at the 3rd cycle of the coin pulse -> coin_sw=0 on the next cycle; after release with coin still held -> one fresh pulse after debounce.
- SOCD (macro defined): raw_p2 = 5'b00011 stable -> p2_l=p2_r=0. Same stimulus with the macro undefined -> p2_l=p2_r=1.
